// File: rtl/vga_framebuffer.sv
// vga_framebuffer: 160x120 RGB332 framebuffer between the vga timing generator and the DAC.
// Revision 1.0 - CPU write port, hardware clear engine, 3-stage pixel read pipeline.
`default_nettype none
`timescale 1ns/1ps

module vga_framebuffer #(
   parameter int          H_PIX  = 160,
   parameter int          V_PIX  = 120,
   parameter int          ADDR_W = 15,
   parameter logic [7:0]  BORDER = 8'h00
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              h_sync_i,
   input  logic              v_sync_i,
   input  logic              in_disp_i,
   input  logic [15:0]       pixel_pos_i,
   input  logic              wr_valid_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [7:0]        wr_data_i,
   output logic              wr_ready_o,
   input  logic              clear_i,
   input  logic [7:0]        clear_color_i,
   output logic              busy_o,
   output logic [7:0]        rgb_o,
   output logic              h_sync_o,
   output logic              v_sync_o,
   output logic              frame_o
);

   localparam int                FB_SIZE = H_PIX * V_PIX;
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(FB_SIZE - 1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] count, count_nxt;
   logic [7:0]        fill, fill_nxt;
   logic              init_done;

   logic              we;
   logic [ADDR_W-1:0] waddr;
   logic [7:0]        wdata;
   logic              wr_fire;
   logic              wr_in_range;

   logic [7:0]        mem [0:FB_SIZE-1];
   logic [7:0]        rd_data;

   logic [7:0]        pos_h, pos_v;
   logic [ADDR_W-1:0] addr_calc;
   logic              fb_hit;

   logic [ADDR_W-1:0] s0_addr;
   logic              s0_fb, s0_disp, s0_hs, s0_vs;
   logic              s1_fb, s1_disp, s1_hs, s1_vs;

   // ---------------- write side: CPU port and clear engine ----------------
   assign wr_ready_o  = init_done & (state == IDLE);
   assign busy_o      = (state == CLEAR);
   assign wr_fire     = wr_valid_i & wr_ready_o;
   assign wr_in_range = 32'(wr_addr_i) < FB_SIZE;

   // Holds wr_ready_o low until the first clock after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         init_done <= 1'b0;
         state     <= IDLE;
         count     <= '0;
         fill      <= 8'h00;
      end else begin
         init_done <= 1'b1;
         state     <= state_nxt;
         count     <= count_nxt;
         fill      <= fill_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      fill_nxt  = fill;
      we        = 1'b0;
      waddr     = wr_addr_i;
      wdata     = wr_data_i;
      case (state)
         IDLE: begin
            if (wr_fire && wr_in_range) begin
               we = 1'b1;
            end
            if (clear_i && init_done) begin
               fill_nxt  = clear_color_i;
               count_nxt = '0;
               state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            we        = 1'b1;
            waddr     = count;
            wdata     = fill;
            count_nxt = count + ADDR_W'(1);
            if (count == LAST) begin
               state_nxt = IDLE;
            end
         end
      endcase
   end

   // Read-before-write on a collision; contents deliberately not reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rd_data <= mem[s0_addr];
   end

   // ---------------- display read pipeline ----------------
   assign pos_h  = pixel_pos_i[7:0];
   assign pos_v  = pixel_pos_i[15:8];
   assign fb_hit = in_disp_i & (32'(pos_h) < H_PIX) & (32'(pos_v) < V_PIX);

   generate
      if (H_PIX == 160) begin : g_shift_add
         assign addr_calc = (ADDR_W'(pos_v) << 7) + (ADDR_W'(pos_v) << 5) + ADDR_W'(pos_h);
      end else begin : g_mult
         assign addr_calc = ADDR_W'(pos_v) * ADDR_W'(H_PIX) + ADDR_W'(pos_h);
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s0_addr  <= '0;
         s0_fb    <= 1'b0;
         s0_disp  <= 1'b0;
         s0_hs    <= 1'b1;
         s0_vs    <= 1'b1;
         s1_fb    <= 1'b0;
         s1_disp  <= 1'b0;
         s1_hs    <= 1'b1;
         s1_vs    <= 1'b1;
         rgb_o    <= 8'h00;
         h_sync_o <= 1'b1;
         v_sync_o <= 1'b1;
         frame_o  <= 1'b0;
      end else begin
         // Off-buffer positions read address 0 so the RAM index stays in range.
         s0_addr  <= fb_hit ? addr_calc : '0;
         s0_fb    <= fb_hit;
         s0_disp  <= in_disp_i;
         s0_hs    <= h_sync_i;
         s0_vs    <= v_sync_i;
         s1_fb    <= s0_fb;
         s1_disp  <= s0_disp;
         s1_hs    <= s0_hs;
         s1_vs    <= s0_vs;
         if (s1_fb) begin
            rgb_o <= rd_data;
         end else if (s1_disp) begin
            rgb_o <= BORDER;
         end else begin
            rgb_o <= 8'h00;
         end
         h_sync_o <= s1_hs;
         v_sync_o <= s1_vs;
         frame_o  <= v_sync_o & ~s1_vs;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_vga_framebuffer.sv
// tb_vga_framebuffer: scoreboard bench for vga_framebuffer (write port, clear engine, pixel pipeline).
`timescale 1ns/1ps

module tb_vga_framebuffer;

   localparam int         H   = 160;
   localparam int         V   = 120;
   localparam int         N   = H * V;
   localparam logic [7:0] BRD = 8'h2A;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        h_sync_i = 1'b1, v_sync_i = 1'b1, in_disp_i = 1'b0;
   logic [15:0] pixel_pos_i = '0;
   logic        wr_valid_i = 1'b0;
   logic [14:0] wr_addr_i = '0;
   logic [7:0]  wr_data_i = '0;
   logic        wr_ready_o;
   logic        clear_i = 1'b0;
   logic [7:0]  clear_color_i = '0;
   logic        busy_o;
   logic [7:0]  rgb_o;
   logic        h_sync_o, v_sync_o, frame_o;

   typedef struct {
      logic [7:0] rgb;
      logic       hs;
      logic       vs;
   } exp_t;

   exp_t       exp_q[$];
   logic [7:0] model [0:N-1];
   int         n_run = 0;
   int         n_fail = 0;
   logic       last_vs = 1'b1;

   vga_framebuffer #(.H_PIX(H), .V_PIX(V), .ADDR_W(15), .BORDER(BRD)) dut (
      .clk(clk), .rst_n(rst_n), .h_sync_i(h_sync_i), .v_sync_i(v_sync_i),
      .in_disp_i(in_disp_i), .pixel_pos_i(pixel_pos_i), .wr_valid_i(wr_valid_i),
      .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i), .wr_ready_o(wr_ready_o),
      .clear_i(clear_i), .clear_color_i(clear_color_i), .busy_o(busy_o),
      .rgb_o(rgb_o), .h_sync_o(h_sync_o), .v_sync_o(v_sync_o), .frame_o(frame_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_rgb(input int v, input int h, input logic disp);
      if (!disp) return 8'h00;
      if (h < H && v < V) return model[v*H + h];
      return BRD;
   endfunction

   // One pixel per clock: drive after the edge, push expectation, return at the negedge.
   task automatic drive_px(input int v, input int h, input logic disp, input logic hs, input logic vs);
      exp_t e;
      @(posedge clk); #1;
      pixel_pos_i = {8'(v), 8'(h)};
      in_disp_i   = disp;
      h_sync_i    = hs;
      v_sync_i    = vs;
      e.rgb = exp_rgb(v, h, disp);
      e.hs  = hs;
      e.vs  = vs;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic do_write(input int addr, input logic [7:0] data);
      @(posedge clk); #1;
      wr_valid_i = 1'b1;
      wr_addr_i  = 15'(addr);
      wr_data_i  = data;
      @(posedge clk); #1;
      wr_valid_i = 1'b0;
      if (addr < N) model[addr] = data;
   endtask

   task automatic test_reset();
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         wr_valid_i    = 1'($urandom_range(0, 1));
         wr_addr_i     = 15'($urandom_range(0, 32767));
         wr_data_i     = 8'($urandom_range(0, 255));
         clear_i       = 1'($urandom_range(0, 1));
         clear_color_i = 8'($urandom_range(0, 255));
         in_disp_i     = 1'($urandom_range(0, 1));
         h_sync_i      = 1'($urandom_range(0, 1));
         v_sync_i      = 1'($urandom_range(0, 1));
         pixel_pos_i   = 16'($urandom_range(0, 65535));
         @(negedge clk);
         n_run++;
         if (rgb_o !== 8'h00 || h_sync_o !== 1'b1 || v_sync_o !== 1'b1 || frame_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got rgb=%h hs=%b vs=%b fr=%b, expected rgb=00 hs=1 vs=1 fr=0",
                     rgb_o, h_sync_o, v_sync_o, frame_o);
         end
         n_run++;
         if (wr_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_busy: got ready=%b busy=%b, expected 0 0", wr_ready_o, busy_o);
         end
      end
      wr_valid_i = 1'b0; clear_i = 1'b0; in_disp_i = 1'b0;
      h_sync_i = 1'b1; v_sync_i = 1'b1; pixel_pos_i = '0;
      rst_n = 1'b1;
      #1;
      n_run++;
      if (wr_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_at_release: got %b expected 0", wr_ready_o);
      end
      @(posedge clk); #1;
      n_run++;
      if (wr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_release: got ready=%b busy=%b expected 1 0", wr_ready_o, busy_o);
      end
   endtask

   task automatic test_write_read();
      exp_t e;
      int hl[5] = '{20, 21, 19, 20, 21};
      do_write(1620, 8'hE3);
      do_write(1621, 8'h5A);
      do_write(1619, 8'h07);
      for (int i = 0; i < 8; i++) begin
         if (i < 5) drive_px(10, hl[i], 1'b1, 1'b1, 1'b1);
         else       drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            n_run++;
            if (rgb_o !== e.rgb) begin
               n_fail++;
               $display("FAIL write_read rgb: got %h expected %h", rgb_o, e.rgb);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_bounds();
      exp_t e;
      int   vl[7] = '{5, 10, 0, 119, 10, 120, 119};
      int   hl[7] = '{200, 20, 0, 159, 20, 0, 160};
      logic dl[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      do_write(0, 8'h11);
      do_write(N - 1, 8'h99);
      @(posedge clk); #1;
      wr_valid_i = 1'b1; wr_addr_i = 15'(N); wr_data_i = 8'h77;
      @(negedge clk);
      n_run++;
      if (wr_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL oob_write_ready: got %b expected 1", wr_ready_o);
      end
      @(posedge clk); #1;
      wr_valid_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i < 7) drive_px(vl[i], hl[i], dl[i], 1'b1, 1'b1);
         else       drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            n_run++;
            if (rgb_o !== e.rgb) begin
               n_fail++;
               $display("FAIL bounds rgb item %0d: got %h expected %h", i - 3, rgb_o, e.rgb);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_back_to_back();
      exp_t e;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         wr_valid_i = 1'b1;
         wr_addr_i  = 15'(2000 + i);
         wr_data_i  = 8'(i * 17 + 3);
         model[2000 + i] = 8'(i * 17 + 3);
         if (i == 7) begin
            // Read of the last address issued while its write is still in flight.
            pixel_pos_i = {8'd12, 8'd87};
            in_disp_i   = 1'b1;
            e.rgb = exp_rgb(12, 87, 1'b1); e.hs = 1'b1; e.vs = 1'b1;
            exp_q.push_back(e);
         end
         @(negedge clk);
         n_run++;
         if (wr_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_ready cycle %0d: got %b expected 1", i, wr_ready_o);
         end
      end
      for (int i = 0; i < 9; i++) begin
         if (i < 6) drive_px(12, 80 + i, 1'b1, 1'b1, 1'b1);
         else       drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         if (i == 0) wr_valid_i = 1'b0;
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            n_run++;
            if (rgb_o !== e.rgb) begin
               n_fail++;
               $display("FAIL b2b rgb: got %h expected %h", rgb_o, e.rgb);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_clear();
      exp_t e;
      int   busy_cnt = 0;
      int   bad_ready = 0;
      int   vl[4] = '{0, 10, 119, 10};
      int   hl[4] = '{0, 20, 159, 21};
      @(posedge clk); #1;
      clear_i = 1'b1; clear_color_i = 8'h1C;
      wr_valid_i = 1'b1; wr_addr_i = 15'd0; wr_data_i = 8'hFF;
      @(negedge clk);
      n_run++;
      if (wr_ready_o !== 1'b1 || busy_o !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_pre: got ready=%b busy=%b expected 1 0", wr_ready_o, busy_o);
      end
      @(posedge clk); #1;
      clear_i = 1'b0; wr_valid_i = 1'b0;
      for (int i = 0; i < N; i++) model[i] = 8'h1C;
      @(negedge clk);
      for (int c = 0; c < 25000; c++) begin
         if (busy_o !== 1'b1) break;
         busy_cnt++;
         if (wr_ready_o !== 1'b0) bad_ready++;
         if (c == 100) begin clear_i = 1'b1; clear_color_i = 8'hE0; end
         if (c == 101) clear_i = 1'b0;
         @(negedge clk);
      end
      n_run++;
      if (busy_cnt != N) begin
         n_fail++;
         $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_cnt, N);
      end
      n_run++;
      if (bad_ready != 0) begin
         n_fail++;
         $display("FAIL clear_ready_low: got %0d cycles with ready=1, expected 0", bad_ready);
      end
      n_run++;
      if (wr_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_ready_return: got %b expected 1", wr_ready_o);
      end
      for (int i = 0; i < 7; i++) begin
         if (i < 4) drive_px(vl[i], hl[i], 1'b1, 1'b1, 1'b1);
         else       drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            n_run++;
            if (rgb_o !== e.rgb) begin
               n_fail++;
               $display("FAIL clear_readback rgb: got %h expected %h", rgb_o, e.rgb);
            end
         end
      end
      exp_q.delete();
   endtask

   task automatic test_sync_align();
      exp_t e;
      int   hc, vc;
      int   frames = 0;
      logic exp_fr;
      int   errs = 0;
      // Scaled-down raster: 40 clocks/line, 15 lines/frame, 3 frames.
      for (int i = 0; i < 1803; i++) begin
         if (i < 1800) begin
            hc = i % 40;
            vc = (i / 40) % 15;
            drive_px(vc + 115, hc + 150, (hc < 20) && (vc < 10),
                     !((hc >= 24) && (hc < 28)), !((vc >= 11) && (vc < 13)));
         end else begin
            drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         end
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            exp_fr  = last_vs & ~e.vs;
            last_vs = e.vs;
            if (frame_o === 1'b1) frames++;
            n_run++;
            if (rgb_o !== e.rgb || h_sync_o !== e.hs || v_sync_o !== e.vs || frame_o !== exp_fr) begin
               n_fail++;
               errs++;
               if (errs < 10)
                  $display("FAIL sync_align item %0d: got rgb=%h hs=%b vs=%b fr=%b expected rgb=%h hs=%b vs=%b fr=%b",
                           i - 3, rgb_o, h_sync_o, v_sync_o, frame_o, e.rgb, e.hs, e.vs, exp_fr);
            end
         end
      end
      n_run++;
      if (frames != 3) begin
         n_fail++;
         $display("FAIL frame_count: got %0d expected 3", frames);
      end
      exp_q.delete();
   endtask

   task automatic test_reset_mid_clear();
      exp_t e;
      int   vl[3] = '{0, 93, 10};
      int   hl[3] = '{100, 120, 20};
      do_write(15000, 8'h55);
      @(posedge clk); #1;
      clear_i = 1'b1; clear_color_i = 8'hA5;
      @(posedge clk); #1;
      clear_i = 1'b0;
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         if (busy_o !== 1'b1) break;
      end
      for (int i = 0; i < 4000; i++) model[i] = 8'hA5;
      rst_n = 1'b0;
      #1;
      n_run++;
      if (busy_o !== 1'b0 || wr_ready_o !== 1'b0) begin
         n_fail++;
         $display("FAIL midclear_reset: got busy=%b ready=%b expected 0 0", busy_o, wr_ready_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_run++;
      if (busy_o !== 1'b0 || wr_ready_o !== 1'b1) begin
         n_fail++;
         $display("FAIL midclear_release: got busy=%b ready=%b expected 0 1", busy_o, wr_ready_o);
      end
      for (int i = 0; i < 6; i++) begin
         if (i < 3) drive_px(vl[i], hl[i], 1'b1, 1'b1, 1'b1);
         else       drive_px(0, 0, 1'b0, 1'b1, 1'b1);
         if (exp_q.size() > 3) begin
            e = exp_q.pop_front();
            n_run++;
            if (rgb_o !== e.rgb) begin
               n_fail++;
               $display("FAIL midclear_readback rgb: got %h expected %h", rgb_o, e.rgb);
            end
         end
      end
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_bounds();
      test_back_to_back();
      test_clear();
      test_sync_align();
      test_reset_mid_clear();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_run, n_fail);
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vga_framebuffer.md
# vga_framebuffer

Pixel-memory stage directly downstream of the `vga` timing generator. Holds a 160x120 RGB332 framebuffer in dual-port block RAM and exposes a valid/ready write port to the CPU/graphics side. Also provides a hardware clear engine. Converts the timing generator's pixel position and display-enable into registered colour output, with syncs delayed to stay aligned with the pixel data.

## Interface
Parameters:
- `H_PIX`, 160, visible framebuffer width in pixels.
- `V_PIX`, 120, visible framebuffer height in pixels.
- `ADDR_W`, 15, framebuffer address width; must satisfy 2^ADDR_W >= H_PIX*V_PIX.
- `BORDER`, 8'h00, colour driven for in-display positions outside the framebuffer.

Ports:
- `clk`  in  1  system clock (50 MHz pixel-rate clock shared with `vga`).
- `rst_n`  in  1  asynchronous, active-low reset.
- `h_sync_i`  in  1  horizontal sync from `vga`, active-low.
- `v_sync_i`  in  1  vertical sync from `vga`, active-low.
- `in_disp_i`  in  1  display-enable from `vga`.
- `pixel_pos_i`  in  16  {v[7:0], h[7:0]} from `vga`.
- `wr_valid_i`  in  1  write request.
- `wr_addr_i`  in  ADDR_W  linear write address (v*H_PIX + h).
- `wr_data_i`  in  8  RGB332 write data.
- `wr_ready_o`  out  1  write port can accept.
- `clear_i`  in  1  start full-buffer clear (level, sampled when idle).
- `clear_color_i`  in  8  fill colour, latched with `clear_i`.
- `busy_o`  out  1  clear in progress.
- `rgb_o`  out  8  RGB332 pixel to DAC.
- `h_sync_o`  out  1  h_sync delayed to align with `rgb_o`.
- `v_sync_o`  out  1  v_sync delayed to align with `rgb_o`.
- `frame_o`  out  1  one-cycle pulse on the falling edge of the delayed v_sync.

## Operation
- Memory: H_PIX*V_PIX bytes, one synchronous read port (display) and one synchronous write port (CPU/clear). Read-first on an address collision: the read returns old data. Memory contents are not reset.
- Read pipeline: 3 stages.
  - S0 registers the inputs and computes `addr = v*H_PIX + h`. The multiply is implemented as (v<<7)+(v<<5)+h for H_PIX=160, at ADDR_W width. It also computes `in_fb = in_disp & (h<H_PIX) & (v<V_PIX)`.
  - S1 performs the RAM read.
  - S2 registers `rgb_o`, which takes one of three values:
    - RAM data if `in_fb`;
    - `BORDER` if in_disp but not `in_fb`;
    - 0 if not in_disp.
  - Syncs and flags travel through matching delay registers.
- Write FSM states: IDLE, CLEAR.
  - IDLE: `wr_ready_o`=1, `busy_o`=0. A handshake (`wr_valid_i & wr_ready_o`) writes `wr_data_i` to `wr_addr_i`. Addresses >= H_PIX*V_PIX are accepted and dropped.
  - IDLE with `clear_i`=1: latch `clear_color_i`, zero the counter, go to CLEAR. A write handshake in the same cycle still completes; the clear later overwrites it.
  - CLEAR: `wr_ready_o`=0, `busy_o`=1. Each cycle writes the latched colour to address = counter and increments the counter. When counter = H_PIX*V_PIX-1 is written, the FSM returns to IDLE the next cycle. `clear_i` is ignored in CLEAR.
  - Display reads continue during CLEAR. Pixels show a mix of old and cleared data.
- `frame_o` fires when delayed v_sync goes 1->0.

## Timing
- Reset values: `rgb_o`=0, `h_sync_o`=1, `v_sync_o`=1, `frame_o`=0, `busy_o`=0, FSM=IDLE, counter=0.
- `wr_ready_o`=0 while `rst_n`=0, and 1 from the first clock after release.
- Latency: `pixel_pos_i`/`in_disp_i`/syncs at edge N appear as `rgb_o`/`h_sync_o`/`v_sync_o` after edge N+3. Relative alignment is preserved exactly.
- Write: a handshake at edge N is visible to a display read issued (S1) at edge N+1 or later.
- Clear duration: H_PIX*V_PIX cycles (19200 at defaults). `busy_o` is high from the edge after `clear_i` sampling through the last fill write. `wr_ready_o` returns high on the same edge `busy_o` falls.
- Reset mid-clear: immediately IDLE, `busy_o`=0, memory left partially filled.
- `frame_o` is high for exactly 1 cycle per frame, in the same cycle `v_sync_o` first reads 0.

## Test plan
- Reset: hold `rst_n`=0 for 5 cycles with toggling inputs -> `rgb_o`=0, syncs=1, `wr_ready_o`=0, `busy_o`=0. After release, `wr_ready_o`=1 one cycle later.
- Write/read-back: write 8'hE3 at addr 10*160+20=1620, then drive pos {8'd10,8'd20} with in_disp=1 -> `rgb_o`=8'hE3 exactly 3 cycles later. The neighbouring pos {10,21} returns its own written value.
- Bounds: in_disp=1 at pos {5,200} -> `BORDER`. in_disp=0 at pos {10,20} -> 0. Write to addr 19200 -> accepted (`wr_ready_o`=1) and no RAM location changes.
- Clear: pulse `clear_i` with colour 8'h1C plus a simultaneous write of 8'hFF to addr 0 -> `busy_o` high for 19200 cycles and `wr_ready_o` low throughout. Afterwards, addrs 0, 1620 and 19199 read 8'h1C. `clear_i` re-pulsed mid-clear has no effect.
- Reset mid-clear: assert `rst_n`=0 at counter ~5000 -> `busy_o`=0 immediately. Addr 100 reads the clear colour and addr 15000 retains its old data.
- Sync alignment: drive full 640x480 `vga` timing -> `h_sync_o`/`v_sync_o` equal the inputs delayed 3 cycles. `frame_o` pulses exactly once per frame, coincident with the first `v_sync_o`=0 cycle.
